// File: rtl/encoder_bank_pkg.sv
// Shared definitions for the encoder bank: bound modes, default parameters
// and the range clamp used by host writes.
package encoder_bank_pkg;

  typedef enum logic {
    SATURATE = 1'b0,
    WRAP     = 1'b1
  } bound_mode_e;

  localparam int DEF_CHANNELS       = 2;
  localparam int DEF_WIDTH          = 16;
  localparam int DEF_DEBOUNCE_WIDTH = 11;
  localparam int DEF_WINDOW_WIDTH   = 20;
  localparam int DEF_VELOCITY_SHIFT = 3;

  // Clamp operates on a fixed wide type; callers zero-extend (WIDTH <= 32).
  localparam int CLAMP_W = 33;

  function automatic logic [CLAMP_W-1:0] clamp(
    input logic [CLAMP_W-1:0] x,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    logic [CLAMP_W-1:0] r;
    if (x < lo) begin
      r = lo;
    end else if (x > hi) begin
      r = hi;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_channel.sv
// One encoder channel: synchroniser, debounce, 4x quadrature decode,
// windowed velocity estimate and the bounded value register.
module encoder_channel
  import encoder_bank_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH,
  parameter int VELOCITY_SHIFT = DEF_VELOCITY_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_raw,
  input  logic             b_raw,
  input  logic             window_last,
  input  logic             we,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             wrap,
  output logic [WIDTH-1:0] value,
  output logic             changed
);

  localparam int VW = WIDTH + VELOCITY_SHIFT + 1;

  // Bit 0 carries phase A, bit 1 carries phase B throughout the input path.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] dec_q, dec_d;
  logic [1:0][DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] vel_q, vel_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;

  logic               step_s;
  logic               dir_s;
  logic               bounds_ok_s;
  logic [VW-1:0]      vel_wide_s;
  logic [WIDTH:0]     nxt_s;
  logic               under_s;
  logic               over_s;
  logic [WIDTH-1:0]   upd_s;
  logic [CLAMP_W-1:0] wr_clamp_s;
  logic               unused_clamp_s;

  // Synchroniser, debounce filter and decode history.
  always_comb begin
    sync1_d = {b_raw, a_raw};
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    dec_d   = db_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (&cnt_q[i]) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_WIDTH'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign step_s = db_q[0] ^ dec_q[0] ^ db_q[1] ^ dec_q[1];
  assign dir_s  = db_q[0] ^ dec_q[1];

  // Pulse counting and velocity latch at the end of each window.
  always_comb begin
    vel_wide_s = (VW'(pulse_q) << VELOCITY_SHIFT) + VW'(1);
    if (window_last) begin
      vel_d   = (vel_wide_s > VW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : vel_wide_s[WIDTH-1:0];
      pulse_d = step_s ? WIDTH'(1) : WIDTH'(0);
    end else begin
      vel_d   = vel_q;
      pulse_d = (step_s && !(&pulse_q)) ? pulse_q + WIDTH'(1) : pulse_q;
    end
  end

  // Step arithmetic in WIDTH+1 bits so carry and borrow stay visible.
  always_comb begin
    nxt_s   = dir_s ? ({1'b0, value_q} + {1'b0, vel_q}) : ({1'b0, value_q} - {1'b0, vel_q});
    under_s = (!dir_s && nxt_s[WIDTH]) || (nxt_s < {1'b0, min_val});
    over_s  = !under_s && (nxt_s > {1'b0, max_val});
    if (bound_mode_e'(wrap) == WRAP) begin
      upd_s = over_s ? min_val : (under_s ? max_val : nxt_s[WIDTH-1:0]);
    end else begin
      upd_s = over_s ? max_val : (under_s ? min_val : nxt_s[WIDTH-1:0]);
    end
  end

  assign wr_clamp_s     = clamp(CLAMP_W'(din), CLAMP_W'(min_val), CLAMP_W'(max_val));
  assign unused_clamp_s = ^wr_clamp_s[CLAMP_W-1:WIDTH];
  assign bounds_ok_s    = (min_val <= max_val);

  // Value and sticky flag: a write beats a step, a set beats an ack.
  always_comb begin
    value_d   = value_q;
    changed_d = changed_q & ~ack;
    if (!bounds_ok_s) begin
      value_d = value_q;
    end else if (we) begin
      value_d = wr_clamp_s[WIDTH-1:0];
    end else if (step_s) begin
      value_d   = upd_s;
      changed_d = 1'b1;
    end else begin
      value_d = value_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      db_q      <= 2'b00;
      dec_q     <= 2'b00;
      cnt_q     <= '0;
      pulse_q   <= '0;
      vel_q     <= WIDTH'(1);
      value_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      vel_q     <= vel_d;
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign value   = value_q;
  assign changed = changed_q;

endmodule

// File: rtl/encoder_bank.sv
// Multi-channel rotary encoder front end: shared velocity window, host
// write/ack decode and the registered read-back of the addressed channel.
module encoder_bank
  import encoder_bank_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH,
  parameter int WINDOW_WIDTH   = DEF_WINDOW_WIDTH,
  parameter int VELOCITY_SHIFT = DEF_VELOCITY_SHIFT,
  parameter int AW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  logic                ack,
  input  logic [WIDTH-1:0]    din,
  input  logic [WIDTH-1:0]    min_val,
  input  logic [WIDTH-1:0]    max_val,
  input  logic                wrap,
  output logic [WIDTH-1:0]    q,
  output logic [CHANNELS-1:0] changed
);

  logic [WINDOW_WIDTH-1:0] window_q, window_d;
  logic                    window_last_s;
  logic [CHANNELS-1:0]     we_s;
  logic [CHANNELS-1:0]     ack_s;
  logic [WIDTH-1:0]        value_s [CHANNELS];
  logic [WIDTH-1:0]        q_q, q_d;

  assign window_d      = window_q + WINDOW_WIDTH'(1);
  assign window_last_s = &window_q;

  // Address decode for host strobes and read-back selection.
  always_comb begin
    q_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      we_s[i]  = we  & (addr == AW'(i));
      ack_s[i] = ack & (addr == AW'(i));
    end
    if (int'(addr) < CHANNELS) begin
      q_d = value_s[addr];
    end else begin
      q_d = '0;
    end
  end

  // Free-running window counter and read-back register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window_q <= '0;
      q_q      <= '0;
    end else begin
      window_q <= window_d;
      q_q      <= q_d;
    end
  end

  assign q = q_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    encoder_channel #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH),
      .VELOCITY_SHIFT (VELOCITY_SHIFT)
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_raw       (a[ch]),
      .b_raw       (b[ch]),
      .window_last (window_last_s),
      .we          (we_s[ch]),
      .ack         (ack_s[ch]),
      .din         (din),
      .min_val     (min_val),
      .max_val     (max_val),
      .wrap        (wrap),
      .value       (value_s[ch]),
      .changed     (changed[ch])
    );
  end

endmodule

// File: tb/tb_encoder_bank.sv
// Directed bench for encoder_bank with short debounce and velocity windows.
module tb_encoder_bank;

  logic        clk;
  logic        rst_n;
  logic [1:0]  a;
  logic [1:0]  b;
  logic [0:0]  addr;
  logic        we;
  logic        ack;
  logic [15:0] din;
  logic [15:0] min_val;
  logic [15:0] max_val;
  logic        wrap;
  logic [15:0] q;
  logic [1:0]  changed;

  int checks = 0;
  int errors = 0;

  encoder_bank #(
    .CHANNELS       (2),
    .WIDTH          (16),
    .DEBOUNCE_WIDTH (2),
    .WINDOW_WIDTH   (6),
    .VELOCITY_SHIFT (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .addr    (addr),
    .we      (we),
    .ack     (ack),
    .din     (din),
    .min_val (min_val),
    .max_val (max_val),
    .wrap    (wrap),
    .q       (q),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after the release, before edge 1 of a fresh window.
  task automatic do_reset();
    rst_n = 1'b0; a = 2'b00; b = 2'b00; addr = 1'b0; we = 1'b0; ack = 1'b0;
    din = 16'd0; min_val = 16'd0; max_val = 16'hFFFF; wrap = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; a = 2'b00; b = 2'b00; addr = 1'b0; we = 1'b0; ack = 1'b0;
    din = 16'd0; min_val = 16'd0; max_val = 16'hFFFF; wrap = 1'b0;
    tick(3);
    check("rst_q", q, 16'd0);
    check("rst_changed", 16'(changed), 16'd0);
    addr = 1'b1;
    tick(1);
    check("rst_q_ch1", q, 16'd0);
    addr = 1'b0;
    rst_n = 1'b1;

    // CW quarter step on ch0: update lands on edge 7
    a[0] = 1'b1;
    tick(6);
    check("cw_changed_early", 16'(changed[0]), 16'd0);
    tick(1);
    check("cw_changed", 16'(changed[0]), 16'd1);
    check("cw_ch1_quiet", 16'(changed[1]), 16'd0);
    check("cw_q_lat", q, 16'd0);
    tick(1);
    check("cw_q", q, 16'd1);
    b[0] = 1'b1;
    tick(8);
    check("cw_q2", q, 16'd2);
    a[0] = 1'b0;
    tick(8);
    check("cw_q3", q, 16'd3);
    addr = 1'b1;
    tick(1);
    check("ch1_value", q, 16'd0);
    addr = 1'b0;

    // 3-cycle glitch on a[1] must be filtered (edge 25..28)
    a[1] = 1'b1;
    tick(3);
    a[1] = 1'b0;
    tick(10);
    check("glitch_changed", 16'(changed[1]), 16'd0);
    addr = 1'b1;
    tick(1);
    check("glitch_value", q, 16'd0);
    addr = 1'b0;

    // Window ends at edge 64 with 3 pulses -> velocity 25
    tick(25);
    b[0] = 1'b0;
    tick(8);
    check("vel_step", q, 16'd28);

    // Saturate at 20 with velocity 25; ack clears the flag
    min_val = 16'd10; max_val = 16'd20; we = 1'b1; din = 16'd19; ack = 1'b1;
    tick(1);
    we = 1'b0; ack = 1'b0;
    check("ack_clear", 16'(changed[0]), 16'd0);
    a[0] = 1'b1;
    tick(1);
    check("wr_19", q, 16'd19);
    tick(6);
    check("sat_changed", 16'(changed[0]), 16'd1);
    tick(1);
    check("sat_max", q, 16'd20);

    // Wrap mode with velocity 1
    do_reset();
    min_val = 16'd10; max_val = 16'd20; wrap = 1'b1; we = 1'b1; din = 16'd20;
    tick(1);
    we = 1'b0;
    a[0] = 1'b1;
    tick(7);
    check("wrap_changed", 16'(changed[0]), 16'd1);
    tick(1);
    check("wrap_up", q, 16'd10);
    a[0] = 1'b0;
    tick(8);
    check("wrap_down", q, 16'd20);
    min_val = 16'd0; we = 1'b1; din = 16'd0;
    tick(1);
    we = 1'b0;
    b[0] = 1'b1;
    tick(1);
    check("wr_zero", q, 16'd0);
    tick(7);
    check("wrap_borrow", q, 16'd20);

    // Write vs step on ch1, set vs ack on ch0
    do_reset();
    max_val = 16'd50;
    a = 2'b11;
    tick(6);
    we = 1'b1; addr = 1'b1; din = 16'd100;
    tick(1);
    we = 1'b0;
    check("wr_beats_step", 16'(changed[1]), 16'd0);
    check("ch0_step", 16'(changed[0]), 16'd1);
    b[0] = 1'b1;
    tick(1);
    check("wr_clamp", q, 16'd50);
    addr = 1'b0;
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("set_beats_ack", 16'(changed[0]), 16'd1);
    tick(1);
    check("ch0_two", q, 16'd2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_alone", 16'(changed[0]), 16'd0);

    // Inverted bounds: write and step both ignored (edge 16..24)
    min_val = 16'd60; we = 1'b1; addr = 1'b1; din = 16'd5; a[0] = 1'b0;
    tick(1);
    we = 1'b0;
    tick(1);
    check("inv_write", q, 16'd50);
    addr = 1'b0;
    tick(6);
    check("inv_step", 16'(changed[0]), 16'd0);
    check("inv_hold", q, 16'd2);

    // Dropped ch1 step still counted: velocity 9 after edge 64, 50-9=41
    min_val = 16'd0;
    tick(40);
    a[1] = 1'b0; addr = 1'b1;
    tick(8);
    check("vel_dropped", q, 16'd41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
